mem_arbiter: RTL and testbench

- Shares the single memory port (proc2mem_*/mem2proc_*) between icache and dcache.
- Each cycle it forwards at most one request to memory and records which requester owns each accepted load tag.
- Returning data is routed to the owner of its tag.
- Dcache has fixed priority, with an aging counter that guarantees the icache forward progress.

---
 rtl/mem_arbiter_pkg.sv | 30 +++
 rtl/mem_tag_table.sv | 72 +++++++
 rtl/mem_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared definitions for the icache/dcache memory-port arbiter: bus command
// encodings, address/size/tag widths and the requester/owner enumerations.
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

    localparam int XLEN         = 32;
    localparam int MEM_SIZE_W   = 2;
    localparam int NUM_MEM_TAGS = 16;
    localparam int TAG_W        = $clog2(NUM_MEM_TAGS);

    localparam logic [1:0] BUS_NONE  = 2'h0;
    localparam logic [1:0] BUS_LOAD  = 2'h1;
    localparam logic [1:0] BUS_STORE = 2'h2;

    // Which cache owns an outstanding load tag.
    typedef enum logic {
        OWNER_ICACHE = 1'b0,
        OWNER_DCACHE = 1'b1
    } arb_owner_t;

    // Which requester, if any, drives the memory port this cycle.
    typedef enum logic [1:0] {
        SEL_NONE   = 2'd0,
        SEL_ICACHE = 2'd1,
        SEL_DCACHE = 2'd2
    } arb_sel_t;

endpackage

// File: rtl/mem_tag_table.sv
// -----------------------------------------------------------------------------
// mem_tag_table
// Tracks which requester owns each outstanding memory load tag.
//
// Ports:
//   clk, reset      clock; synchronous active-low reset clears all valid bits
//   alloc_en_i      record a newly accepted load
//   alloc_tag_i     tag returned by memory for that load
//   alloc_owner_i   requester that issued the load
//   free_en_i       a return is present on lookup_tag_i; retire the entry
//   lookup_tag_i    tag of the data coming back from memory
//   hit_o           lookup_tag_i is non-zero and currently owned
//   owner_o         owner of lookup_tag_i (meaningful only with hit_o)
//   busy_o          at least one tag is outstanding
//
// Lookup always reads the registered state, so a return and an allocate on
// the same tag in one cycle see the old owner; the allocate is applied after
// the free, leaving the entry valid with the new owner.
// -----------------------------------------------------------------------------
module mem_tag_table
    import mem_arbiter_pkg::*;
#(
    parameter int NUM_TAGS = NUM_MEM_TAGS,
    localparam int TW      = $clog2(NUM_TAGS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            alloc_en_i,
    input  logic [TW-1:0]   alloc_tag_i,
    input  arb_owner_t      alloc_owner_i,
    input  logic            free_en_i,
    input  logic [TW-1:0]   lookup_tag_i,
    output logic            hit_o,
    output arb_owner_t      owner_o,
    output logic            busy_o
);

    logic [NUM_TAGS-1:0] valid_q;
    logic [NUM_TAGS-1:0] valid_d;
    arb_owner_t          owner_q [NUM_TAGS];

    always_comb begin
        valid_d = valid_q;
        if (free_en_i) begin
            valid_d[lookup_tag_i] = 1'b0;
        end
        // Applied after the free so a same-tag allocate wins.
        if (alloc_en_i && (alloc_tag_i != '0)) begin
            valid_d[alloc_tag_i] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Owner bits are qualified by valid, so they need no reset.
    always_ff @(posedge clk) begin
        if (alloc_en_i && (alloc_tag_i != '0)) begin
            owner_q[alloc_tag_i] <= alloc_owner_i;
        end
    end

    assign hit_o   = (lookup_tag_i != '0) && valid_q[lookup_tag_i];
    assign owner_o = owner_q[lookup_tag_i];
    assign busy_o  = |valid_q;

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one memory port between the icache and the dcache. Requests and
// returns pass through combinationally; only the tag-owner table, the icache
// starvation counter and the sticky tag_error flag are registered.
//
// Ports:
//   clk, reset              clock; synchronous active-low reset
//   icache2arb_*            icache request (addr, command, size)
//   dcache2arb_*            dcache request (addr, data, command, size)
//   arb2icache_*            accept tag, return data and return tag to icache
//   arb2dcache_*            accept tag, return data and return tag to dcache
//   proc2mem_*              forwarded request to memory
//   mem2proc_*              memory accept tag, return data and return tag
//   tag_error               sticky: a return arrived on an unowned tag
//   busy                    at least one load tag is outstanding
//
// The dcache wins by default. After STARVE_LIMIT consecutive cycles in which
// the icache was denied, the icache is preferred until memory accepts it.
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int NUM_TAGS     = NUM_MEM_TAGS
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic [XLEN-1:0]       icache2arb_addr,
    input  logic [1:0]            icache2arb_command,
    input  logic [MEM_SIZE_W-1:0] icache2arb_size,

    input  logic [XLEN-1:0]       dcache2arb_addr,
    input  logic [63:0]           dcache2arb_data,
    input  logic [1:0]            dcache2arb_command,
    input  logic [MEM_SIZE_W-1:0] dcache2arb_size,

    output logic [3:0]            arb2icache_response,
    output logic [63:0]           arb2icache_data,
    output logic [3:0]            arb2icache_tag,

    output logic [3:0]            arb2dcache_response,
    output logic [63:0]           arb2dcache_data,
    output logic [3:0]            arb2dcache_tag,

    output logic [XLEN-1:0]       proc2mem_addr,
    output logic [63:0]           proc2mem_data,
    output logic [1:0]            proc2mem_command,
    output logic [MEM_SIZE_W-1:0] proc2mem_size,

    input  logic [3:0]            mem2proc_response,
    input  logic [63:0]           mem2proc_data,
    input  logic [3:0]            mem2proc_tag,

    output logic                  tag_error,
    output logic                  busy
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_q;
    logic [CNT_W-1:0] starve_d;
    logic             tag_error_q;
    logic             tag_error_d;

    logic             ic_req;
    logic             dc_req;
    arb_sel_t         sel;
    logic             alloc_en;
    arb_owner_t       alloc_owner;
    logic             free_en;
    logic             ret_hit;
    arb_owner_t       ret_owner;
    logic             tbl_busy;

    assign ic_req = (icache2arb_command != BUS_NONE);
    assign dc_req = (dcache2arb_command != BUS_NONE);

    // Grant: reset suppresses any selection, which in turn forces the memory
    // port idle and both accept responses to zero.
    always_comb begin
        sel = SEL_NONE;
        if (reset) begin
            if (ic_req && (!dc_req || (starve_q == STARVE_MAX))) begin
                sel = SEL_ICACHE;
            end else if (dc_req) begin
                sel = SEL_DCACHE;
            end
        end
    end

    // Request forwarding and accept routing.
    always_comb begin
        proc2mem_addr       = '0;
        proc2mem_data       = '0;
        proc2mem_command    = BUS_NONE;
        proc2mem_size       = '0;
        arb2icache_response = '0;
        arb2dcache_response = '0;
        case (sel)
            SEL_ICACHE: begin
                proc2mem_addr       = icache2arb_addr;
                proc2mem_command    = icache2arb_command;
                proc2mem_size       = icache2arb_size;
                arb2icache_response = mem2proc_response;
            end
            SEL_DCACHE: begin
                proc2mem_addr       = dcache2arb_addr;
                proc2mem_data       = dcache2arb_data;
                proc2mem_command    = dcache2arb_command;
                proc2mem_size       = dcache2arb_size;
                arb2dcache_response = mem2proc_response;
            end
            default: begin
            end
        endcase
    end

    // Only accepted loads get an owner; stores never come back.
    assign alloc_en    = (proc2mem_command == BUS_LOAD) && (mem2proc_response != '0);
    assign alloc_owner = (sel == SEL_ICACHE) ? OWNER_ICACHE : OWNER_DCACHE;
    assign free_en     = (mem2proc_tag != '0);

    mem_tag_table #(
        .NUM_TAGS      (NUM_TAGS)
    ) u_tag_table (
        .clk           (clk),
        .reset         (reset),
        .alloc_en_i    (alloc_en),
        .alloc_tag_i   (mem2proc_response),
        .alloc_owner_i (alloc_owner),
        .free_en_i     (free_en),
        .lookup_tag_i  (mem2proc_tag),
        .hit_o         (ret_hit),
        .owner_o       (ret_owner),
        .busy_o        (tbl_busy)
    );

    // Return routing: only the owner of a valid tag sees the data.
    always_comb begin
        arb2icache_tag  = '0;
        arb2icache_data = '0;
        arb2dcache_tag  = '0;
        arb2dcache_data = '0;
        if (reset && ret_hit) begin
            if (ret_owner == OWNER_ICACHE) begin
                arb2icache_tag  = mem2proc_tag;
                arb2icache_data = mem2proc_data;
            end else begin
                arb2dcache_tag  = mem2proc_tag;
                arb2dcache_data = mem2proc_data;
            end
        end
    end

    // Starvation counter: a refused icache-priority grant holds the count so
    // the icache keeps priority until memory finally accepts it.
    always_comb begin
        starve_d = starve_q;
        if (!ic_req) begin
            starve_d = '0;
        end else if (sel == SEL_ICACHE) begin
            if (mem2proc_response != '0) begin
                starve_d = '0;
            end
        end else if (sel == SEL_DCACHE) begin
            if (starve_q != STARVE_MAX) begin
                starve_d = starve_q + 1'b1;
            end
        end
    end

    assign tag_error_d = tag_error_q | (free_en && !ret_hit);

    always_ff @(posedge clk) begin
        if (!reset) begin
            starve_q    <= '0;
            tag_error_q <= 1'b0;
        end else begin
            starve_q    <= starve_d;
            tag_error_q <= tag_error_d;
        end
    end

    assign tag_error = tag_error_q;
    assign busy      = tbl_busy;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed, table-driven bench for mem_arbiter. Each row is one clock cycle:
// inputs are applied after the falling edge, outputs are compared before the
// next rising edge. busy/tag_error columns give the registered state as seen
// during that row (i.e. the result of earlier rows).
// g  : expected grant   0 = none, 1 = icache, 2 = dcache
// rt : expected return  0 = nobody, 1 = icache, 2 = dcache
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam logic [1:0] N = BUS_NONE;
    localparam logic [1:0] L = BUS_LOAD;
    localparam logic [1:0] S = BUS_STORE;
    localparam logic [1:0] IC_SIZE = 2'd2;
    localparam logic [1:0] DC_SIZE = 2'd3;

    logic        clk;
    logic        reset;
    logic [31:0] ic_addr;
    logic [1:0]  ic_cmd;
    logic [1:0]  ic_size;
    logic [31:0] dc_addr;
    logic [63:0] dc_data;
    logic [1:0]  dc_cmd;
    logic [1:0]  dc_size;
    logic [3:0]  ic_resp;
    logic [63:0] ic_rdata;
    logic [3:0]  ic_tag;
    logic [3:0]  dc_resp;
    logic [63:0] dc_rdata;
    logic [3:0]  dc_tag;
    logic [31:0] p_addr;
    logic [63:0] p_data;
    logic [1:0]  p_cmd;
    logic [1:0]  p_size;
    logic [3:0]  m_resp;
    logic [63:0] m_data;
    logic [3:0]  m_tag;
    logic        tag_error;
    logic        busy;

    mem_arbiter #(
        .STARVE_LIMIT        (4),
        .NUM_TAGS            (16)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .icache2arb_addr     (ic_addr),
        .icache2arb_command  (ic_cmd),
        .icache2arb_size     (ic_size),
        .dcache2arb_addr     (dc_addr),
        .dcache2arb_data     (dc_data),
        .dcache2arb_command  (dc_cmd),
        .dcache2arb_size     (dc_size),
        .arb2icache_response (ic_resp),
        .arb2icache_data     (ic_rdata),
        .arb2icache_tag      (ic_tag),
        .arb2dcache_response (dc_resp),
        .arb2dcache_data     (dc_rdata),
        .arb2dcache_tag      (dc_tag),
        .proc2mem_addr       (p_addr),
        .proc2mem_data       (p_data),
        .proc2mem_command    (p_cmd),
        .proc2mem_size       (p_size),
        .mem2proc_response   (m_resp),
        .mem2proc_data       (m_data),
        .mem2proc_tag        (m_tag),
        .tag_error           (tag_error),
        .busy                (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [1:0]  icc;
        logic [31:0] ica;
        logic [1:0]  dcc;
        logic [31:0] dca;
        logic [63:0] dcd;
        logic [3:0]  resp;
        logic [3:0]  mtag;
        logic [63:0] mdata;
        int          g;
        int          rt;
        logic        busy;
        logic        err;
    } vec_t;

    vec_t vq[$];
    int   total = 0;
    int   bad   = 0;

    task automatic add(input logic rst, input logic [1:0] icc, input logic [31:0] ica,
                       input logic [1:0] dcc, input logic [31:0] dca, input logic [63:0] dcd,
                       input logic [3:0] resp, input logic [3:0] mtag, input logic [63:0] mdata,
                       input int g, input int rt, input logic eb, input logic ee);
        vec_t v;
        v.rst = rst;   v.icc = icc;   v.ica = ica;
        v.dcc = dcc;   v.dca = dca;   v.dcd = dcd;
        v.resp = resp; v.mtag = mtag; v.mdata = mdata;
        v.g = g;       v.rt = rt;     v.busy = eb;  v.err = ee;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input int row, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    initial begin
        logic [63:0] e_pa, e_pd;
        logic [1:0]  e_pc, e_ps;

        reset   = 1'b0;
        ic_addr = '0; ic_cmd = N; ic_size = IC_SIZE;
        dc_addr = '0; dc_data = '0; dc_cmd = N; dc_size = DC_SIZE;
        m_resp  = '0; m_data = '0; m_tag = '0;

        // --- dcache load, accept tag 1, return to dcache; reset forces outputs
        add(0, N, 0,         L, 'h1000, 'h1111,     1, 0, 0,                     0, 0, 0, 0);
        add(1, N, 0,         L, 'h1000, 'h1111,     1, 0, 0,                     2, 0, 0, 0);
        add(1, N, 0,         N, 0,      0,          0, 1, 64'hDEADBEEF00001000,  0, 2, 1, 0);
        add(1, N, 0,         N, 0,      0,          0, 0, 0,                     0, 0, 0, 0);
        // --- icache tag 2, dcache tag 3, returns out of order
        add(1, L, 'h2000,    N, 0,      0,          2, 0, 0,                     1, 0, 0, 0);
        add(1, N, 0,         L, 'h3000, 0,          3, 0, 0,                     2, 0, 1, 0);
        add(1, N, 0,         N, 0,      0,          0, 3, 64'hA3,                0, 2, 1, 0);
        add(1, N, 0,         N, 0,      0,          0, 2, 64'hB2,                0, 1, 1, 0);
        add(1, N, 0,         N, 0,      0,          0, 0, 0,                     0, 0, 0, 0);
        // --- store allocates nothing; spurious return sets sticky tag_error
        add(1, N, 0,         S, 'h4000, 'hFEEDFACE, 4, 0, 0,                     2, 0, 0, 0);
        add(1, N, 0,         N, 0,      0,          0, 4, 64'h1234,              0, 0, 0, 0);
        add(1, N, 0,         N, 0,      0,          0, 0, 0,                     0, 0, 0, 1);
        // --- starvation: 4 dcache grants, then icache, then dcache again
        add(1, L, 'h5000,    L, 'h6000, 0,          6, 0, 0,                     2, 0, 0, 1);
        add(1, L, 'h5000,    L, 'h6000, 0,          7, 0, 0,                     2, 0, 1, 1);
        add(1, L, 'h5000,    L, 'h6000, 0,          8, 0, 0,                     2, 0, 1, 1);
        add(1, L, 'h5000,    L, 'h6000, 0,          9, 0, 0,                     2, 0, 1, 1);
        add(1, L, 'h5000,    L, 'h6000, 0,         10, 0, 0,                     1, 0, 1, 1);
        add(1, L, 'h5000,    L, 'h6000, 0,         11, 0, 0,                     2, 0, 1, 1);
        add(1, N, 0,         N, 0,      0,          0,10, 64'hC10,               0, 1, 1, 1);
        // --- refused icache-priority grants keep the icache selected
        add(1, L, 'h5000,    L, 'h6000, 0,         12, 0, 0,                     2, 0, 1, 1);
        add(1, L, 'h5000,    L, 'h6000, 0,         13, 0, 0,                     2, 0, 1, 1);
        add(1, L, 'h5000,    L, 'h6000, 0,         14, 0, 0,                     2, 0, 1, 1);
        add(1, L, 'h5000,    L, 'h6000, 0,         15, 0, 0,                     2, 0, 1, 1);
        add(1, L, 'h5000,    L, 'h6000, 0,          0, 0, 0,                     1, 0, 1, 1);
        add(1, L, 'h5000,    L, 'h6000, 0,          0, 0, 0,                     1, 0, 1, 1);
        add(1, L, 'h5000,    L, 'h6000, 0,          0, 0, 0,                     1, 0, 1, 1);
        add(1, L, 'h5000,    L, 'h6000, 0,          1, 0, 0,                     1, 0, 1, 1);
        add(1, L, 'h5000,    L, 'h6000, 0,          0, 0, 0,                     2, 0, 1, 1);
        // --- same-tag return + allocate: old owner gets data, new owner kept
        add(1, N, 0,         L, 'h7000, 0,          3, 0, 0,                     2, 0, 1, 1);
        add(1, L, 'h7100,    N, 0,      0,          3, 3, 64'hD3,                1, 2, 1, 1);
        add(1, N, 0,         N, 0,      0,          0, 3, 64'hE3,                0, 1, 1, 1);
        // --- reset mid-flight drops ownership
        add(1, N, 0,         L, 'h8000, 0,          5, 0, 0,                     2, 0, 1, 1);
        add(0, L, 'h8100,    L, 'h8200, 0,          7, 5, 64'hF5,                0, 0, 1, 1);
        add(1, N, 0,         N, 0,      0,          0, 5, 64'hF5,                0, 0, 0, 0);
        add(1, N, 0,         N, 0,      0,          0, 0, 0,                     0, 0, 0, 1);

        repeat (2) @(posedge clk);

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            reset   = vq[i].rst;
            ic_cmd  = vq[i].icc;  ic_addr = vq[i].ica;
            dc_cmd  = vq[i].dcc;  dc_addr = vq[i].dca;  dc_data = vq[i].dcd;
            m_resp  = vq[i].resp; m_tag   = vq[i].mtag; m_data  = vq[i].mdata;
            #2;
            e_pc = N; e_pa = '0; e_pd = '0; e_ps = '0;
            if (vq[i].g == 1) begin
                e_pc = vq[i].icc; e_pa = 64'(vq[i].ica); e_ps = IC_SIZE;
            end else if (vq[i].g == 2) begin
                e_pc = vq[i].dcc; e_pa = 64'(vq[i].dca); e_pd = vq[i].dcd; e_ps = DC_SIZE;
            end
            chk("proc2mem_command", i, 64'(p_cmd), 64'(e_pc));
            chk("proc2mem_addr",    i, 64'(p_addr), e_pa);
            chk("proc2mem_data",    i, p_data, e_pd);
            chk("proc2mem_size",    i, 64'(p_size), 64'(e_ps));
            chk("icache_response",  i, 64'(ic_resp), (vq[i].g == 1) ? 64'(vq[i].resp) : 64'd0);
            chk("dcache_response",  i, 64'(dc_resp), (vq[i].g == 2) ? 64'(vq[i].resp) : 64'd0);
            chk("icache_tag",       i, 64'(ic_tag),  (vq[i].rt == 1) ? 64'(vq[i].mtag) : 64'd0);
            chk("icache_data",      i, ic_rdata,     (vq[i].rt == 1) ? vq[i].mdata : 64'd0);
            chk("dcache_tag",       i, 64'(dc_tag),  (vq[i].rt == 2) ? 64'(vq[i].mtag) : 64'd0);
            chk("dcache_data",      i, dc_rdata,     (vq[i].rt == 2) ? vq[i].mdata : 64'd0);
            chk("busy",             i, 64'(busy),      64'(vq[i].busy));
            chk("tag_error",        i, 64'(tag_error), 64'(vq[i].err));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
